// File: rtl/icache_sa_if.sv
// Fetch-side and memory-side signals of icache_sa, grouped as one bundle.
// slave = cache view, master = the IF stage plus memory_control view.
interface icache_sa_if #(
   parameter int ADDR_W = 32
);
   logic              inst_read_i;
   logic [ADDR_W-1:0] inst_addr_i;
   logic              flush_i;
   logic              inst_valid_o;
   logic [31:0]       inst_data_o;
   logic              mem_read_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic              mem_busy_i;
   logic              mem_valid_i;
   logic [31:0]       mem_data_i;

   modport slave (
      input  inst_read_i, inst_addr_i, flush_i, mem_busy_i, mem_valid_i, mem_data_i,
      output inst_valid_o, inst_data_o, mem_read_o, mem_addr_o
   );

   modport master (
      output inst_read_i, inst_addr_i, flush_i, mem_busy_i, mem_valid_i, mem_data_i,
      input  inst_valid_o, inst_data_o, mem_read_o, mem_addr_o
   );
endinterface

// File: rtl/icache_sa.sv
// 2-way set-associative I-cache, LRU replacement, word-by-word refill; ICACHE_PERF_EN adds hit/miss counters.
// Hits answer in the request cycle; a miss stalls while mem_busy_i=1 and costs at least 2*LINE_WORDS+1 cycles.
module icache_sa #(
   parameter int ADDR_W     = 32,
   parameter int NUM_SETS   = 64,
   parameter int LINE_WORDS = 4
) (
   input  logic        clk,
   input  logic        rst,
   icache_sa_if.slave  bus
`ifdef ICACHE_PERF_EN
   ,
   output logic [31:0] perf_hit_o,
   output logic [31:0] perf_miss_o
`endif
);
   localparam int OFF_W = $clog2(LINE_WORDS);
   localparam int IDX_W = $clog2(NUM_SETS);
   localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
   state_t state, state_nxt;

   logic [31:0]         data_mem [2][NUM_SETS][LINE_WORDS];
   logic [TAG_W-1:0]    tag_mem  [2][NUM_SETS];
   logic [NUM_SETS-1:0] valid    [2];
   logic [NUM_SETS-1:0] lru;

   logic [ADDR_W-1:0] base;
   logic [OFF_W-1:0]  cnt;
   logic              victim;
   logic              flush_pending;
   logic [ADDR_W-1:0] addr_q;

   logic [OFF_W-1:0]  off;
   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  tag;
   logic [IDX_W-1:0]  ridx;
   logic [ADDR_W-1:0] req_addr;
   logic              hit0, hit1, hit, miss, victim_sel;
   logic              start, issue, last;
   logic              unused_addr_bits;

   assign off  = bus.inst_addr_i[OFF_W+1:2];
   assign idx  = bus.inst_addr_i[OFF_W+IDX_W+1:OFF_W+2];
   assign tag  = bus.inst_addr_i[ADDR_W-1:OFF_W+IDX_W+2];
   assign ridx = base[OFF_W+IDX_W+1:OFF_W+2];
   assign unused_addr_bits = &{1'b0, bus.inst_addr_i[1:0]};

   assign hit0 = valid[0][idx] && (tag_mem[0][idx] == tag);
   assign hit1 = valid[1][idx] && (tag_mem[1][idx] == tag);
   assign hit  = bus.inst_read_i && !bus.flush_i && (hit0 || hit1);
   assign miss = bus.inst_read_i && !bus.flush_i && !(hit0 || hit1);
   assign victim_sel = !valid[0][idx] ? 1'b0 : (!valid[1][idx] ? 1'b1 : lru[idx]);

   assign bus.inst_valid_o = hit;
   assign bus.inst_data_o  = !hit ? 32'h0 : (hit0 ? data_mem[0][idx][off] : data_mem[1][idx][off]);

   assign req_addr       = base | {{(ADDR_W-OFF_W-2){1'b0}}, cnt, 2'b00};
   assign bus.mem_read_o = issue;
   assign bus.mem_addr_o = issue ? req_addr : addr_q;

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      issue     = 1'b0;
      last      = 1'b0;
      case (state)
         IDLE: if (miss) begin
            start     = 1'b1;
            state_nxt = REQ;
         end
         REQ: if (!bus.mem_busy_i) begin
            issue     = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: if (bus.mem_valid_i) begin
            if (cnt == OFF_W'(LINE_WORDS-1)) begin
               last      = 1'b1;
               state_nxt = IDLE;
            end else begin
               state_nxt = REQ;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         cnt           <= '0;
         base          <= '0;
         victim        <= 1'b0;
         flush_pending <= 1'b0;
         addr_q        <= '0;
         valid[0]      <= '0;
         valid[1]      <= '0;
         lru           <= '0;
      end else begin
         state <= state_nxt;
         if (issue) addr_q <= req_addr;
         if (hit) lru[idx] <= hit0;
         if (start) begin
            base   <= {bus.inst_addr_i[ADDR_W-1:OFF_W+2], {(OFF_W+2){1'b0}}};
            cnt    <= '0;
            victim <= victim_sel;
            // the victim's old tag must not hit while its words are being overwritten
            valid[victim_sel][idx] <= 1'b0;
         end
         if (state == WAIT && bus.mem_valid_i && !last) cnt <= cnt + 1'b1;
         if (last) begin
            valid[victim][ridx] <= !flush_pending;
            lru[ridx]           <= ~victim;
            flush_pending       <= 1'b0;
         end
         if (bus.flush_i) begin
            valid[0] <= '0;
            valid[1] <= '0;
            lru      <= '0;
            if (state != IDLE && !last) flush_pending <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (state == WAIT && bus.mem_valid_i) data_mem[victim][ridx][cnt] <= bus.mem_data_i;
      if (last) tag_mem[victim][ridx] <= base[ADDR_W-1:OFF_W+IDX_W+2];
   end

`ifdef ICACHE_PERF_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_hit_o  <= '0;
         perf_miss_o <= '0;
      end else begin
         if (hit && perf_hit_o != 32'hFFFF_FFFF) perf_hit_o <= perf_hit_o + 32'd1;
         if (start && perf_miss_o != 32'hFFFF_FFFF) perf_miss_o <= perf_miss_o + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_icache_sa.sv
// Bench for icache_sa: directed vectors and sequences, then random traffic against an LRU set model.
module tb_icache_sa;
   localparam int LW = 4;

   logic clk = 1'b0;
   logic rst;
   int tests = 0;
   int fails = 0;

   icache_sa_if #(.ADDR_W(32)) bus ();
`ifdef ICACHE_PERF_EN
   logic [31:0] perf_hit, perf_miss;
`endif

   icache_sa #(.ADDR_W(32), .NUM_SETS(64), .LINE_WORDS(LW)) dut (
      .clk(clk), .rst(rst), .bus(bus)
`ifdef ICACHE_PERF_EN
      , .perf_hit_o(perf_hit), .perf_miss_o(perf_miss)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return (32'h11 * {30'd0, a[3:2]} + 32'h11) ^ {a[23:4], 12'h000};
   endfunction

   // memory_control stand-in: answers each request after lat (or random) extra cycles
   logic [31:0] rlog[$];
   int nreads = 0, nvalid = 0, lat = 0, wcnt = 0;
   bit pend = 0, rand_lat = 0;
   logic [31:0] paddr;
   always @(negedge clk) begin
      bus.mem_valid_i = 1'b0;
      if (pend) begin
         if (wcnt > 0) wcnt--;
         else begin
            bus.mem_valid_i = 1'b1;
            bus.mem_data_i  = mem_fn(paddr);
            pend = 0;
            nvalid++;
         end
      end
      if (rst && bus.mem_read_o) begin
         pend  = 1;
         paddr = bus.mem_addr_o;
         wcnt  = rand_lat ? int'($urandom_range(0, 2)) : lat;
         nreads++;
         rlog.push_back(paddr);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h required %h", nm, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Request a, expect hit or miss in the first cycle, then wait for the hit.
   task automatic access(input logic [31:0] a, input bit exp_hit, input string nm, output int pen);
      bus.inst_read_i = 1'b1;
      bus.inst_addr_i = a;
      #2;
      chk({nm, "_first"}, {bus.inst_valid_o, bus.inst_data_o}, {exp_hit, exp_hit ? mem_fn(a) : 32'h0});
      pen = 0;
      while (!bus.inst_valid_o && pen < 200) begin
         cyc();
         #2;
         pen++;
      end
      chk({nm, "_fill"}, {bus.inst_valid_o, bus.inst_data_o}, {1'b1, mem_fn(a)});
      cyc();
      bus.inst_read_i = 1'b0;
   endtask

   task automatic wait_valids(input int t, input string nm);
      int n = 0;
      while (nvalid < t && n < 300) begin
         cyc();
         n++;
      end
      chk(nm, 64'(nvalid >= t), 64'd1);
   endtask

   typedef struct {
      logic        rd;
      logic        fl;
      logic [31:0] addr;
      logic        vld;
      logic [31:0] dat;
   } vec_t;
   vec_t vt[8];

   int m_tag[2][2];
   int m_cnt[2];
   bit m_act, m_pend;
   int m_set, m_rtag, m_words;

   initial begin
      int pen, v0, r0;
      bit seen;
      vt[0] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h11};
      vt[1] = '{1'b1, 1'b0, 32'h4,  1'b1, 32'h22};
      vt[2] = '{1'b1, 1'b0, 32'hC,  1'b1, 32'h44};
      vt[3] = '{1'b0, 1'b0, 32'h4,  1'b0, 32'h0};
      vt[4] = '{1'b1, 1'b0, 32'h10, 1'b0, 32'h0};
      vt[5] = '{1'b1, 1'b0, 32'h8,  1'b1, 32'h33};
      vt[6] = '{1'b1, 1'b1, 32'h0,  1'b0, 32'h0};
      vt[7] = '{1'b1, 1'b0, 32'h4,  1'b0, 32'h0};

      rst = 1'b1;
      bus.inst_read_i = 1'b1;
      bus.inst_addr_i = 32'h0;
      bus.flush_i     = 1'b0;
      bus.mem_busy_i  = 1'b0;
      #1 rst = 1'b0;
      #2;
      chk("rst_outputs", {bus.inst_valid_o, bus.inst_data_o, bus.mem_read_o},
          {1'b0, 32'h0, 1'b0});
      chk("rst_mem_addr", bus.mem_addr_o, 32'h0);
      cyc();
      rst = 1'b1;

      // cold miss
      access(32'h0, 1'b0, "cold", pen);
      chk("cold_penalty", pen, 2 * LW + 1);
      chk("cold_nreads", nreads, 4);
      for (int k = 0; k < 4; k++) chk($sformatf("cold_addr%0d", k), rlog[k], 32'(4 * k));
      access(32'h8, 1'b1, "cold_hit8", pen);
      chk("cold_no_read", nreads, 4);
`ifdef ICACHE_PERF_EN
      chk("perf_hit", perf_hit, 2);
      chk("perf_miss", perf_miss, 1);
`endif

      // vector table; includes a miss and a flush that lands mid-refill
      v0 = nvalid;
      for (int i = 0; i < 8; i++) begin
         bus.inst_read_i = vt[i].rd;
         bus.flush_i     = vt[i].fl;
         bus.inst_addr_i = vt[i].addr;
         #2;
         chk($sformatf("vec%0d", i), {bus.inst_valid_o, bus.inst_data_o}, {vt[i].vld, vt[i].dat});
         cyc();
      end
      bus.inst_read_i = 1'b0;
      bus.flush_i     = 1'b0;
      wait_valids(v0 + 4, "vec_refill_done");
      access(32'h10, 1'b0, "flushpend_line", pen);
      access(32'h0, 1'b0, "flushed_zero", pen);

      // associativity and LRU
      access(32'h400, 1'b0, "as_400", pen);
      access(32'h0,   1'b1, "as_hit0", pen);
      access(32'h400, 1'b1, "as_hit400", pen);
      access(32'h0,   1'b1, "as_touch0", pen);
      access(32'h800, 1'b0, "as_800", pen);
      access(32'h0,   1'b1, "as_keep0", pen);
      access(32'h400, 1'b0, "as_evict400", pen);

      // busy stall
      r0 = nreads;
      bus.mem_busy_i  = 1'b1;
      bus.inst_read_i = 1'b1;
      bus.inst_addr_i = 32'h200;
      #2;
      seen = bus.mem_read_o;
      cyc();
      bus.inst_read_i = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #2;
         seen |= bus.mem_read_o;
         cyc();
      end
      chk("busy_no_read", seen, 1'b0);
      bus.mem_busy_i = 1'b0;
      #2;
      chk("busy_release_read", {bus.mem_read_o, bus.mem_addr_o}, {1'b1, 32'h200});
      cyc();
      #2;
      chk("busy_single_pulse", {bus.mem_read_o, bus.mem_addr_o}, {1'b0, 32'h200});
      cyc();
      access(32'h200, 1'b0, "busy_fill", pen);
      chk("busy_nreads", nreads - r0, 4);

      // flush after the second word of a 0x100 refill
      v0 = nvalid;
      r0 = nreads;
      bus.inst_read_i = 1'b1;
      bus.inst_addr_i = 32'h100;
      cyc();
      bus.inst_read_i = 1'b0;
      wait_valids(v0 + 2, "fl_two_words");
      bus.flush_i = 1'b1;
      cyc();
      bus.flush_i = 1'b0;
      wait_valids(v0 + 4, "fl_refill_done");
      cyc();
      chk("fl_nreads", nreads - r0, 4);
      access(32'h100, 1'b0, "fl_100_miss", pen);
      access(32'h0,   1'b0, "fl_000_miss", pen);

      // redirect to a cached line during a refill
      v0 = nvalid;
      bus.inst_read_i = 1'b1;
      bus.inst_addr_i = 32'h200;
      cyc();
      bus.inst_addr_i = 32'h0;
      #2;
      chk("redir_hit", {bus.inst_valid_o, bus.inst_data_o}, {1'b1, 32'h11});
      chk("redir_req", {bus.mem_read_o, bus.mem_addr_o}, {1'b1, 32'h200});
      cyc();
      bus.inst_read_i = 1'b0;
      wait_valids(v0 + 4, "redir_refill_done");
      cyc();
      access(32'h200, 1'b1, "redir_line_valid", pen);

      // asynchronous reset in the middle of a refill, late response after release
      lat = 4;
      v0 = nvalid;
      bus.inst_read_i = 1'b1;
      bus.inst_addr_i = 32'h300;
      cyc();
      bus.inst_read_i = 1'b0;
      cyc();
      bus.inst_read_i = 1'b1;
      bus.inst_addr_i = 32'h0;
      #1;
      chk("pre_rst_hit", {bus.inst_valid_o, bus.inst_data_o}, {1'b1, 32'h11});
      rst = 1'b0;
      #1;
      chk("rst_async_outputs", {bus.inst_valid_o, bus.inst_data_o, bus.mem_read_o},
          {1'b0, 32'h0, 1'b0});
      chk("rst_async_mem_addr", bus.mem_addr_o, 32'h0);
      cyc();
      cyc();
      rst = 1'b1;
      bus.inst_read_i = 1'b0;
      wait_valids(v0 + 1, "rst_late_valid");
      cyc();
      cyc();
      lat = 0;
      access(32'h0, 1'b0, "post_rst_miss", pen);
      chk("post_rst_penalty", pen, 2 * LW + 1);

      // random traffic against a recency-ordered set model (index 0 = most recent)
      rst = 1'b0;
      cyc();
      rst = 1'b1;
      m_cnt[0] = 0;
      m_cnt[1] = 0;
      m_act = 0;
      m_pend = 0;
      m_words = 0;
      m_set = 0;
      m_rtag = 0;
      rand_lat = 1;
      for (int c = 0; c < 3000; c++) begin
         int st, tg, ts;
         bit rd, fl, eh, act_pre;
         logic [31:0] a;
         ts = int'($urandom_range(0, 3));
         tg = (ts == 3) ? 32'h3FFFFF : ts;
         st = int'($urandom_range(0, 1));
         a  = (32'(tg) << 10) | (32'(st) << 4) | (32'($urandom_range(0, 3)) << 2);
         rd = ($urandom_range(0, 9) < 8);
         fl = ($urandom_range(0, 59) == 0);
         bus.inst_read_i = rd;
         bus.flush_i     = fl;
         bus.inst_addr_i = a;
         bus.mem_busy_i  = ($urandom_range(0, 3) == 0);
         #2;
         eh = rd && !fl && ((m_cnt[st] > 0 && m_tag[st][0] == tg) || (m_cnt[st] > 1 && m_tag[st][1] == tg));
         chk("rand_lookup", {bus.inst_valid_o, bus.inst_data_o}, {eh, eh ? mem_fn(a) : 32'h0});
         if (bus.mem_read_o)
            chk("rand_req_addr", {m_act, bus.mem_addr_o},
                {1'b1, (32'(m_rtag) << 10) | (32'(m_set) << 4) | 32'(4 * m_words)});
         @(negedge clk);
         #1;
         act_pre = m_act;
         if (eh && m_cnt[st] == 2 && m_tag[st][1] == tg) begin
            m_tag[st][1] = m_tag[st][0];
            m_tag[st][0] = tg;
         end
         if (act_pre && bus.mem_valid_i) begin
            if (m_words == LW - 1) begin
               if (!fl && !m_pend) begin
                  m_tag[m_set][1] = m_tag[m_set][0];
                  m_tag[m_set][0] = m_rtag;
                  m_cnt[m_set]++;
               end
               m_act = 0;
            end else begin
               m_words++;
            end
         end
         if (!act_pre && rd && !fl && !eh) begin
            if (m_cnt[st] == 2) m_cnt[st] = 1;
            m_act = 1;
            m_set = st;
            m_rtag = tg;
            m_words = 0;
            m_pend = 0;
         end
         if (fl) begin
            m_cnt[0] = 0;
            m_cnt[1] = 0;
            if (m_act) m_pend = 1;
         end
         cyc();
      end
      bus.inst_read_i = 1'b0;
      bus.flush_i     = 1'b0;
      bus.mem_busy_i  = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
